// File: rtl/seq_divider.sv
// seq_divider: radix-2 restoring divider, one quotient bit per clock.
// Optional two's-complement mode when DIV_SIGNED_EN is defined.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   start request, sampled in IDLE or DONE only
//   a, b  dividend / divisor, captured on an accepted start
//   busy  high while iterating
//   done  one-cycle pulse, q/r/dz valid
//   q, r  quotient / remainder, held until the next done
//   dz    divide-by-zero flag of the last operation
module seq_divider #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] q,
  output logic [W-1:0] r,
  output logic         dz
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [W-1:0]  dvd;
  logic [W-1:0]  dvs;
  logic [W:0]    p;
  logic [CW-1:0] cnt;
  logic          dz_r;

  logic          accept;
  logic          last;
  logic [W:0]    p_sh;
  logic [W:0]    trial;
  logic          carry;
  logic [W:0]    p_nx;
  logic [W-1:0]  dvd_nx;
  logic [W-1:0]  ld_a;
  logic [W-1:0]  ld_b;
  logic [W-1:0]  q_fin;
  logic [W-1:0]  r_fin;

  // P never exceeds the divisor after a step, so its top bit stays 0.
  logic unused;
  assign unused = p[W];

  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (cnt == CW'(W - 1));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // One restoring step: shift {P, dividend} left, then trial-subtract
  // the divisor as P + ~{0,divisor} + 1; the carry-out says T >= 0.
  always_comb begin
    p_sh           = {p[W-1:0], dvd[W-1]};
    {carry, trial} = {1'b0, p_sh}
                   + {1'b0, ~{1'b0, dvs}}
                   + {{(W + 1){1'b0}}, 1'b1};
    p_nx           = carry ? trial : p_sh;
    dvd_nx         = {dvd[W-2:0], carry};
  end

`ifdef DIV_SIGNED_EN
  logic qneg;
  logic rneg;

  assign ld_a = a[W-1] ? (W'(0) - a) : a;
  assign ld_b = b[W-1] ? (W'(0) - b) : b;

  // On divide-by-zero the quotient stays all ones; the remainder still
  // takes the dividend's sign, which restores r == a.
  always_comb begin
    q_fin = dvd_nx;
    r_fin = p_nx[W-1:0];
    if (qneg && !dz_r) q_fin = W'(0) - dvd_nx;
    if (rneg) r_fin = W'(0) - p_nx[W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qneg <= 1'b0;
      rneg <= 1'b0;
    end else if (accept) begin
      qneg <= a[W-1] ^ b[W-1];
      rneg <= a[W-1];
    end
  end
`else
  assign ld_a  = a;
  assign ld_b  = b;
  assign q_fin = dvd_nx;
  assign r_fin = p_nx[W-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd  <= '0;
      dvs  <= '0;
      p    <= '0;
      cnt  <= '0;
      dz_r <= 1'b0;
      q    <= '0;
      r    <= '0;
      dz   <= 1'b0;
    end else if (accept) begin
      dvd  <= ld_a;
      dvs  <= ld_b;
      p    <= '0;
      cnt  <= '0;
      dz_r <= (b == '0);
    end else if (state == RUN) begin
      dvd <= dvd_nx;
      p   <= p_nx;
      cnt <= cnt + CW'(1);
      if (last) begin
        q  <= q_fin;
        r  <= r_fin;
        dz <= dz_r;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider.
// Expected results are queued at start and compared on done.
module tb_seq_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         dz;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  seq_divider #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .r     (r),
    .dz    (dz)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x,
                                 input logic [W-1:0] y);
    exp_t e;
    e.dz = (y == '0);
    if (y == '0) begin
      e.q = '1;
      e.r = x;
    end
`ifdef DIV_SIGNED_EN
    else if (x == {1'b1, {(W - 1){1'b0}}} && y == '1) begin
      e.q = x;
      e.r = '0;
    end else begin
      e.q = W'($signed(x) / $signed(y));
      e.r = W'($signed(x) % $signed(y));
    end
`else
    else begin
      e.q = x / y;
      e.r = x % y;
    end
`endif
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("q", 32'(q), 32'(mon_e.q));
        check("r", 32'(r), 32'(mon_e.r));
        check("dz", 32'(dz), 32'(mon_e.dz));
        check("busy_in_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc  = 0;
    for (int i = 1; i <= 4 * W; i++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) check("timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y);
    int lat;
    int bc;
    sb.push_back(model(x, y));
    @(negedge clk);
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, bc);
    check("latency", 32'(lat), 32'(W + 1));
    check("busy_cycles", 32'(bc), 32'(W));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    int   lat;
    int   bc;
    int   nd;
    exp_t first;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q", 32'(q), 32'd0);
    check("rst_r", 32'(r), 32'd0);
    check("rst_dz", 32'(dz), 32'd0);
    rst = 1'b0;

    run_op(8'd200, 8'd7);
    run_op(8'd255, 8'd1);
    run_op(8'd3, 8'd10);
    run_op(8'd5, 8'd0);
    run_op(8'd10, 8'd2);
    for (int i = 0; i < 6; i++) begin
      run_op(W'($urandom), W'($urandom_range(1, 255)));
    end

    // start held high through RUN (ignored) and DONE (accepted)
    first = model(8'd200, 8'd7);
    sb.push_back(first);
    @(negedge clk);
    a     = 8'd200;
    b     = 8'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    a = 8'd100;
    b = 8'd9;
    sb.push_back(model(8'd100, 8'd9));
    wait_done(lat, bc);
    check("b2b_lat1", 32'(lat), 32'(W + 1));
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_done_fall", 32'(done), 32'd0);
    check("hold_q", 32'(q), 32'(first.q));
    check("hold_r", 32'(r), 32'(first.r));
    wait_done(lat, bc);
    check("b2b_lat2", 32'(lat), 32'(W + 1));

    // reset in the middle of an operation
    @(negedge clk);
    a     = 8'd200;
    b     = 8'd7;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_q", 32'(q), 32'd0);
    check("abort_r", 32'(r), 32'd0);
    check("abort_dz", 32'(dz), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    nd  = 0;
    repeat (2 * W) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("abort_no_done", 32'(nd), 32'd0);
    run_op(8'd200, 8'd7);

`ifdef DIV_SIGNED_EN
    run_op(8'h9C, 8'd7);
    run_op(8'd100, 8'hF9);
    run_op(8'h80, 8'hFF);
    run_op(8'hFB, 8'd0);
`endif

    repeat (2) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
